// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared register map, bit positions and word width for the SPI slave port
package spi_slave_pkg;

    localparam int DATABITS_C = 8;
    localparam int ADDR_W     = 3;
    localparam int REG_W      = 16;

    localparam logic [ADDR_W-1:0] ADDR_RXDATA  = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_TXDATA  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CONTROL = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_EOP     = 3'd6;

    localparam int BIT_ROE  = 3;
    localparam int BIT_TOE  = 4;
    localparam int BIT_TMT  = 5;
    localparam int BIT_TRDY = 6;
    localparam int BIT_RRDY = 7;
    localparam int BIT_E    = 8;
    localparam int BIT_EOP  = 9;

    // Control bits line up with the status bits they enable; TMT has no enable.
    localparam logic [REG_W-1:0] CTRL_MASK = 16'h03D8;

endpackage

// File: rtl/spi_slave_port_if.sv
// rtl/spi_slave_port_if.sv - CPU register bus of the SPI slave port
interface spi_slave_port_if;
    import spi_slave_pkg::*;

    logic              spi_select;
    logic [ADDR_W-1:0] mem_addr;
    logic              read_n;
    logic              write_n;
    logic [REG_W-1:0]  data_from_cpu;
    logic [REG_W-1:0]  data_to_cpu;
    logic              irq;
    logic              dataavailable;
    logic              readyfordata;

    modport slave (
        input  spi_select, mem_addr, read_n, write_n, data_from_cpu,
        output data_to_cpu, irq, dataavailable, readyfordata
    );

    modport master (
        output spi_select, mem_addr, read_n, write_n, data_from_cpu,
        input  data_to_cpu, irq, dataavailable, readyfordata
    );
endinterface

// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - two-flop synchronizers and edge pulses for SCLK, SS_n and MOSI
module spi_slave_sync (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic ss_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_rise,
    output logic ss_fall,
    output logic selected,
    output logic mosi_s
);
    logic [1:0] sclk_ff, ss_ff, mosi_ff;
    logic       sclk_d, ss_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_ff <= 2'b11;
            ss_ff   <= 2'b11;
            mosi_ff <= 2'b00;
            sclk_d  <= 1'b1;
            ss_d    <= 1'b1;
        end else begin
            sclk_ff <= {sclk_ff[0], sclk};
            ss_ff   <= {ss_ff[0], ss_n};
            mosi_ff <= {mosi_ff[0], mosi};
            sclk_d  <= sclk_ff[1];
            ss_d    <= ss_ff[1];
        end
    end

    assign sclk_rise = sclk_ff[1] & ~sclk_d;
    assign sclk_fall = ~sclk_ff[1] & sclk_d;
    assign ss_rise   = ss_ff[1] & ~ss_d;
    assign ss_fall   = ~ss_ff[1] & ss_d;
    assign selected  = ~ss_ff[1];
    assign mosi_s    = mosi_ff[1];
endmodule

// File: rtl/spi_slave_port.sv
// rtl/spi_slave_port.sv - CPOL=1/CPHA=1 SPI slave with CPU register port; SPI_SLAVE_EOP_EN adds end-of-packet detect
module spi_slave_port
    import spi_slave_pkg::*;
#(
    parameter int DATABITS = DATABITS_C
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            SCLK,
    input  logic            SS_n,
    input  logic            MOSI,
    output logic            MISO,
    output logic            MISO_oe,
    spi_slave_port_if.slave bus
);
    localparam int CNT_W = $clog2(DATABITS);

    logic                sclk_rise, sclk_fall, ss_rise, ss_fall, selected, mosi_s;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATABITS-1:0] rx_shift, rx_holding, rx_next;
    logic [DATABITS-1:0] tx_shift, tx_holding, tx_next;
    logic                tx_primed, rrdy, roe, toe, eop;
    logic [REG_W-1:0]    control, status, eop_value, rd_mux;
    logic                wr_stb, rd_stb, byte_done, byte_load, byte_shift;

    spi_slave_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .sclk      (SCLK),
        .ss_n      (SS_n),
        .mosi      (MOSI),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_rise   (ss_rise),
        .ss_fall   (ss_fall),
        .selected  (selected),
        .mosi_s    (mosi_s)
    );

    assign wr_stb     = bus.spi_select & ~bus.write_n;
    assign rd_stb     = bus.spi_select & ~bus.read_n;
    assign rx_next    = {rx_shift[DATABITS-2:0], mosi_s};
    assign byte_done  = selected & sclk_rise & (bit_cnt == CNT_W'(DATABITS - 1));
    assign byte_load  = selected & sclk_fall & (bit_cnt == '0);
    assign byte_shift = selected & sclk_fall & (bit_cnt != '0);
    assign tx_next    = byte_load ? (tx_primed ? tx_holding : '0) : (tx_shift << 1);
    assign MISO_oe    = selected;

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            rx_holding <= '0;
            tx_shift   <= '0;
            MISO       <= 1'b1;
        end else begin
            // Any select transition starts a fresh byte; a partial byte is dropped.
            if (ss_rise || ss_fall) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (selected && sclk_rise) begin
                rx_shift <= rx_next;
                bit_cnt  <= byte_done ? '0 : bit_cnt + CNT_W'(1);
                if (byte_done)
                    rx_holding <= rx_next;
            end
            if (byte_load || byte_shift) begin
                tx_shift <= tx_next;
                MISO     <= tx_next[DATABITS-1];
            end
        end
    end

    always_comb begin
        status           = '0;
        status[BIT_ROE]  = roe;
        status[BIT_TOE]  = toe;
        status[BIT_TMT]  = ~selected & ~tx_primed;
        status[BIT_TRDY] = ~tx_primed;
        status[BIT_RRDY] = rrdy;
        status[BIT_E]    = roe | toe;
        status[BIT_EOP]  = eop;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.mem_addr)
            ADDR_RXDATA:  rd_mux = REG_W'(rx_holding);
            ADDR_STATUS:  rd_mux = status;
            ADDR_CONTROL: rd_mux = control;
            ADDR_EOP:     rd_mux = eop_value;
            default:      rd_mux = '0;
        endcase
    end

    // SPI-side events are applied last so a byte completion or load wins over CPU clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_holding      <= '0;
            tx_primed       <= 1'b0;
            rrdy            <= 1'b0;
            roe             <= 1'b0;
            toe             <= 1'b0;
            control         <= '0;
            bus.data_to_cpu <= '0;
            bus.irq         <= 1'b0;
        end else begin
            if (wr_stb) begin
                case (bus.mem_addr)
                    ADDR_TXDATA: begin
                        if (tx_primed) begin
                            toe <= 1'b1;
                        end else begin
                            tx_holding <= bus.data_from_cpu[DATABITS-1:0];
                            tx_primed  <= 1'b1;
                        end
                    end
                    ADDR_STATUS: begin
                        rrdy <= 1'b0;
                        roe  <= 1'b0;
                        toe  <= 1'b0;
                    end
                    ADDR_CONTROL: control <= bus.data_from_cpu & CTRL_MASK;
                    default: ;
                endcase
            end
            if (rd_stb) begin
                bus.data_to_cpu <= rd_mux;
                if (bus.mem_addr == ADDR_RXDATA)
                    rrdy <= 1'b0;
            end
            if (byte_load) begin
                if (tx_primed)
                    tx_primed <= 1'b0;
                else
                    toe <= 1'b1;
            end
            if (byte_done) begin
                rrdy <= 1'b1;
                if (rrdy)
                    roe <= 1'b1;
            end
            bus.irq <= |(status & control);
        end
    end

    assign bus.dataavailable = rrdy;
    assign bus.readyfordata  = ~tx_primed;

`ifdef SPI_SLAVE_EOP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            eop_value <= '0;
            eop       <= 1'b0;
        end else begin
            if (wr_stb && bus.mem_addr == ADDR_EOP)
                eop_value <= bus.data_from_cpu;
            if (wr_stb && bus.mem_addr == ADDR_STATUS)
                eop <= 1'b0;
            if (wr_stb && bus.mem_addr == ADDR_TXDATA &&
                bus.data_from_cpu[DATABITS-1:0] == eop_value[DATABITS-1:0])
                eop <= 1'b1;
            if (byte_done && rx_next == eop_value[DATABITS-1:0])
                eop <= 1'b1;
        end
    end
`else
    assign eop_value = '0;
    assign eop       = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_port.sv
// tb/tb_spi_slave_port.sv - scoreboard bench for spi_slave_port; honours SPI_SLAVE_EOP_EN
module tb_spi_slave_port;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic reset, SCLK, SS_n, MOSI, MISO, MISO_oe;

    spi_slave_port_if bif ();

    spi_slave_port #(.DATABITS(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .SCLK    (SCLK),
        .SS_n    (SS_n),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .MISO_oe (MISO_oe),
        .bus     (bif)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] rd_q[$];
    logic [7:0]  miso_q[$];

    // Byte-level reference model of the register file
    logic [7:0]  m_hold, m_rx;
    logic [15:0] m_ctrl, m_eopval;
    bit          m_primed, m_rrdy, m_roe, m_toe, m_eop, m_sel;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] m_status();
        logic [15:0] s;
        s = 16'h0;
        s[3] = m_roe;
        s[4] = m_toe;
        s[5] = !m_sel && !m_primed;
        s[6] = !m_primed;
        s[7] = m_rrdy;
        s[8] = m_roe || m_toe;
        s[9] = m_eop;
        return s;
    endfunction

    task automatic model_reset();
        m_hold = 8'h00; m_rx = 8'h00; m_ctrl = 16'h0; m_eopval = 16'h0;
        m_primed = 0; m_rrdy = 0; m_roe = 0; m_toe = 0; m_eop = 0;
    endtask

    task automatic cpu_write(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        bif.spi_select = 1'b1; bif.write_n = 1'b0; bif.mem_addr = addr; bif.data_from_cpu = data;
        case (addr)
            3'd1: begin
                if (m_primed) m_toe = 1;
                else begin m_hold = data[7:0]; m_primed = 1; end
`ifdef SPI_SLAVE_EOP_EN
                if (data[7:0] == m_eopval[7:0]) m_eop = 1;
`endif
            end
            3'd2: begin m_rrdy = 0; m_roe = 0; m_toe = 0; m_eop = 0; end
            3'd3: m_ctrl = data & 16'h03D8;
`ifdef SPI_SLAVE_EOP_EN
            3'd6: m_eopval = data;
`endif
            default: ;
        endcase
        @(negedge clk);
        bif.spi_select = 1'b0; bif.write_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [2:0] addr);
        logic [15:0] exp;
        @(negedge clk);
        case (addr)
            3'd0: exp = {8'h00, m_rx};
            3'd2: exp = m_status();
            3'd3: exp = m_ctrl;
            3'd6: exp = m_eopval;
            default: exp = 16'h0;
        endcase
        rd_q.push_back(exp);
        if (addr == 3'd0) m_rrdy = 0;
        bif.spi_select = 1'b1; bif.read_n = 1'b0; bif.mem_addr = addr;
        @(negedge clk);
        bif.spi_select = 1'b0; bif.read_n = 1'b1;
    endtask

    task automatic check_flags();
        repeat (2) @(negedge clk);
        check("rrdy_pin", {15'h0, bif.dataavailable}, {15'h0, m_rrdy});
        check("trdy_pin", {15'h0, bif.readyfordata}, {15'h0, !m_primed});
        check("irq_pin", {15'h0, bif.irq}, {15'h0, |(m_status() & m_ctrl)});
    endtask

    task automatic ss_low();
        @(negedge clk);
        SS_n = 1'b0; m_sel = 1;
        repeat (6) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (HALF) @(negedge clk);
        SS_n = 1'b1; m_sel = 0;
        repeat (8) @(negedge clk);
    endtask

    // Master side of one byte (possibly truncated); the slave loads its byte at the first falling edge.
    task automatic spi_byte(input logic [7:0] v, input int nbits);
        logic [7:0] tx;
        if (m_primed) begin tx = m_hold; m_primed = 0; end
        else begin tx = 8'h00; m_toe = 1; end
        if (nbits == 8) miso_q.push_back(tx);
        for (int i = 0; i < nbits; i++) begin
            repeat (HALF) @(negedge clk);
            SCLK = 1'b0; MOSI = v[7-i];
            repeat (HALF) @(negedge clk);
            SCLK = 1'b1;
        end
        if (nbits == 8) begin
            if (m_rrdy) m_roe = 1;
            m_rrdy = 1;
            m_rx = v;
`ifdef SPI_SLAVE_EOP_EN
            if (v == m_eopval[7:0]) m_eop = 1;
`endif
        end
    endtask

    // Read-data monitor: any read accepted at a clock edge is checked just after that edge.
    initial begin
        bit req;
        forever begin
            @(posedge clk);
            req = bif.spi_select && !bif.read_n;
            #1;
            if (req) begin
                if (rd_q.size() == 0) check("rd_underflow", 16'h1, 16'h0);
                else check("rd_data", bif.data_to_cpu, rd_q.pop_front());
            end
        end
    end

    // MISO monitor: master-side sampling on SCLK rising edges; partial bytes dropped on deselect.
    initial begin
        int cnt;
        logic [7:0] sh;
        cnt = 0; sh = 8'h00;
        forever begin
            @(posedge SCLK or posedge SS_n);
            if (SS_n === 1'b1) cnt = 0;
            else begin
                check("miso_oe", {15'h0, MISO_oe}, 16'h1);
                sh = {sh[6:0], MISO};
                cnt++;
                if (cnt == 8) begin
                    cnt = 0;
                    if (miso_q.size() == 0) check("miso_underflow", 16'h1, 16'h0);
                    else check("miso_byte", {8'h00, sh}, {8'h00, miso_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #3_000_000;
        miscompares++;
        $display("FAIL timeout: got running expected finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        logic [2:0] addrs[5];
        int k;
        addrs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
        reset = 1'b1; SCLK = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
        bif.spi_select = 1'b0; bif.read_n = 1'b1; bif.write_n = 1'b1;
        bif.mem_addr = 3'd0; bif.data_from_cpu = 16'h0;
        model_reset(); m_sel = 0;
        repeat (4) @(negedge clk);
        check("rst_miso", {15'h0, MISO}, 16'h1);
        check("rst_miso_oe", {15'h0, MISO_oe}, 16'h0);
        check("rst_data", bif.data_to_cpu, 16'h0);
        check("rst_irq", {15'h0, bif.irq}, 16'h0);
        check("rst_rrdy", {15'h0, bif.dataavailable}, 16'h0);
        check("rst_trdy", {15'h0, bif.readyfordata}, 16'h1);
        reset = 1'b0;
        cpu_read(3'd2);

        // Echo: tx 0xA5 out while 0x3C comes in
        cpu_write(3'd1, 16'h00A5);
        ss_low(); spi_byte(8'h3C, 8); ss_high();
        check_flags();
        cpu_read(3'd0);
        check_flags();

        // Two-byte frame without draining rx: overrun and underrun
        ss_low(); spi_byte(8'h11, 8); spi_byte(8'h22, 8); ss_high();
        cpu_read(3'd0);
        cpu_read(3'd2);
        cpu_write(3'd2, 16'h0);

        // Underrun only, then status clear
        ss_low(); spi_byte(8'hFF, 8); ss_high();
        cpu_read(3'd2);
        cpu_write(3'd2, 16'h0);
        cpu_read(3'd2);

        // Abort after 5 bits, then a full byte
        ss_low(); spi_byte(8'hF0, 5); ss_high();
        ss_low(); spi_byte(8'h81, 8); ss_high();
        cpu_read(3'd0);
        cpu_read(3'd2);
        cpu_write(3'd2, 16'h0);

        // irq trails RRDY by one cycle
        cpu_write(3'd3, 16'h0080);
        check_flags();
        ss_low(); spi_byte(8'h5A, 8);
        k = 0;
        while (!bif.dataavailable && k < 20) begin @(negedge clk); k++; end
        check("rrdy_rise", {15'h0, bif.dataavailable}, 16'h1);
        check("irq_lag0", {15'h0, bif.irq}, 16'h0);
        @(negedge clk);
        check("irq_lag1", {15'h0, bif.irq}, 16'h1);
        ss_high();
        cpu_write(3'd3, 16'h0);
        cpu_write(3'd2, 16'h0);

        // End-of-packet match
        cpu_write(3'd6, 16'h0042);
        ss_low(); spi_byte(8'h42, 8); ss_high();
        cpu_read(3'd2);
        cpu_read(3'd6);
        cpu_write(3'd2, 16'h0);

        // Reset in the middle of a byte
        cpu_write(3'd1, 16'h0033);
        ss_low(); spi_byte(8'hC3, 4);
        @(negedge clk); reset = 1'b1; model_reset();
        repeat (2) @(negedge clk); reset = 1'b0;
        ss_high();
        check_flags();
        cpu_read(3'd2);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 6))
                0: cpu_write(3'd1, 16'($urandom_range(0, 65535)));
                1: cpu_read(addrs[$urandom_range(0, 4)]);
                2: cpu_write(3'd2, 16'h0);
                3: cpu_write(3'd3, 16'($urandom_range(0, 65535)));
                4: cpu_write(3'd6, 16'($urandom_range(0, 3)) + 16'h0040);
                5: check_flags();
                default: begin
                    ss_low();
                    for (int b = 0; b < int'($urandom_range(1, 2)); b++)
                        spi_byte(8'($urandom_range(0, 3)) + 8'h40, 8);
                    if ($urandom_range(0, 3) == 0) spi_byte(8'($urandom_range(0, 255)), $urandom_range(1, 7));
                    ss_high();
                end
            endcase
        end
        check_flags();
        cpu_read(3'd2);
        cpu_read(3'd0);
        repeat (4) @(negedge clk);
        check("rd_q_empty", 16'(rd_q.size()), 16'h0);
        check("miso_q_empty", 16'(miso_q.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
